ttl_pulse_analyzer: RTL and testbench

Receive-side counterpart of the TTL pulse generator. The block samples an asynchronous TTL input, measures each pulse's high width and its rising-edge-to-rising-edge period in `clk` cycles, and counts pulses. It reports one measurement record per pulse and finishes on a target pulse count or an inactivity timeout. It sits on the input side of the pulse subsystem and is used for loopback self-test of the generator and for characterising external trigger sources.

---
 rtl/ttl_pkg.sv | 12 +
 rtl/ttl_sync_edge.sv | 31 +++
 rtl/ttl_pulse_analyzer.sv | 142 ++++++++++++++
 tb/tb_ttl_pulse_analyzer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared TTL pulse subsystem defaults and the analyzer FSM state encoding.
package ttl_pkg;
    localparam int CNT_W_DEF = 32;
    localparam int NUM_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_t;
endpackage

// File: rtl/ttl_sync_edge.sv
// Synchroniser for an asynchronous TTL input followed by a registered edge detector.
// rise/fall are mutually exclusive single-cycle pulses, SYNC_STAGES+1 clk edges after the input moves.
module ttl_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   level_s;

    assign level_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            level_q <= level_s;
            rise    <= level_s & ~level_q;
            fall    <= ~level_s & level_q;
        end
    end
endmodule

// File: rtl/ttl_pulse_analyzer.sv
// Measures high width and rise-to-rise period of TTL pulses, one record per completed pulse.
// Capture ends on a target pulse count or an inactivity timeout; arm is ignored while busy.
module ttl_pulse_analyzer
    import ttl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int NUM_W       = NUM_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ttl_in,
    input  logic             arm,
    input  logic [NUM_W-1:0] pulse_count,
    input  logic [CNT_W-1:0] timeout,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] width_meas,
    output logic [CNT_W-1:0] period_meas,
    output logic [NUM_W-1:0] pulse_num,
    output logic             done,
    output logic             timed_out
);
    state_t           state_q, state_d;
    logic             rise, fall;
    logic [CNT_W-1:0] hi_cnt, per_cnt, prev_per, gap_cnt, gap_inc, tmo_q;
    logic [NUM_W-1:0] target_q, num_inc;
    logic             tmo_hit, count_hit;
    logic             do_arm, do_meas, do_finish, do_tmo;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [NUM_W-1:0] sat_num(input logic [NUM_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ttl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ttl_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign gap_inc   = sat_cnt(gap_cnt);
    assign num_inc   = sat_num(pulse_num);
    // The timeout fires on the edge where gap_cnt reaches the limit; any edge that cycle wins.
    assign tmo_hit   = (tmo_q != '0) && (gap_inc == tmo_q) && !rise && !fall;
    assign count_hit = (target_q != '0) && (num_inc == target_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (arm) state_d = ST_WAIT_RISE;
            ST_WAIT_RISE: if (rise) state_d = ST_HIGH;
                          else if (tmo_hit) state_d = ST_IDLE;
            ST_HIGH:      if (fall) state_d = count_hit ? ST_IDLE : ST_LOW;
                          else if (tmo_hit) state_d = ST_IDLE;
            ST_LOW:       if (rise) state_d = ST_HIGH;
                          else if (tmo_hit) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        do_arm    = (state_q == ST_IDLE) && arm;
        do_meas   = (state_q == ST_HIGH) && fall;
        do_finish = busy && (state_d == ST_IDLE);
        do_tmo    = busy && tmo_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt      <= '0;
            per_cnt     <= '0;
            prev_per    <= '0;
            gap_cnt     <= '0;
            tmo_q       <= '0;
            target_q    <= '0;
            meas_valid  <= 1'b0;
            width_meas  <= '0;
            period_meas <= '0;
            pulse_num   <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
        end else if (do_arm) begin
            hi_cnt      <= '0;
            per_cnt     <= '0;
            prev_per    <= '0;
            gap_cnt     <= '0;
            tmo_q       <= timeout;
            target_q    <= pulse_count;
            meas_valid  <= 1'b0;
            width_meas  <= '0;
            period_meas <= '0;
            pulse_num   <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            meas_valid <= do_meas;
            if (rise || fall) gap_cnt <= '0;
            else if (busy)    gap_cnt <= gap_inc;

            case (state_q)
                ST_WAIT_RISE: if (rise) begin
                    hi_cnt  <= 1;
                    per_cnt <= 1;
                end
                ST_HIGH: begin
                    hi_cnt  <= sat_cnt(hi_cnt);
                    per_cnt <= sat_cnt(per_cnt);
                    if (fall) begin
                        width_meas  <= hi_cnt;
                        period_meas <= prev_per;
                        pulse_num   <= num_inc;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        prev_per <= per_cnt;
                        hi_cnt   <= 1;
                        per_cnt  <= 1;
                    end else begin
                        per_cnt  <= sat_cnt(per_cnt);
                    end
                end
                default: ;
            endcase

            if (do_finish) done      <= 1'b1;
            if (do_tmo)    timed_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ttl_pulse_analyzer.sv
// Bench for ttl_pulse_analyzer: expected records are queued as pulses are driven and
// compared when meas_valid strobes; a second CNT_W=8 instance covers counter saturation.
module tb_ttl_pulse_analyzer;
    import ttl_pkg::*;

    typedef struct {
        int unsigned w;
        int unsigned p;
        int unsigned n;
        bit          fin;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ttl_in = 1'b0;
    logic        arm = 1'b0;
    logic [15:0] pulse_count = '0;
    logic [31:0] timeout = '0;
    logic        busy, meas_valid, done, timed_out;
    logic [31:0] width_meas, period_meas;
    logic [15:0] pulse_num;

    logic        ttl8 = 1'b0;
    logic        arm8 = 1'b0;
    logic [15:0] pc8 = '0;
    logic [7:0]  tmo8 = '0;
    logic        busy8, mv8, done8, to8;
    logic [7:0]  width8, period8;
    logic [15:0] num8;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_mv_cyc = 0;
    int   idle_cyc = 0;
    rec_t sb[$];
    rec_t mon_r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ttl_pulse_analyzer dut (
        .clk(clk), .rst_n(rst_n), .ttl_in(ttl_in), .arm(arm),
        .pulse_count(pulse_count), .timeout(timeout), .busy(busy),
        .meas_valid(meas_valid), .width_meas(width_meas), .period_meas(period_meas),
        .pulse_num(pulse_num), .done(done), .timed_out(timed_out)
    );

    ttl_pulse_analyzer #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ttl_in(ttl8), .arm(arm8),
        .pulse_count(pc8), .timeout(tmo8), .busy(busy8),
        .meas_valid(mv8), .width_meas(width8), .period_meas(period8),
        .pulse_num(num8), .done(done8), .timed_out(to8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (meas_valid) begin
            last_mv_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", meas_valid, 0);
            end else begin
                mon_r = sb.pop_front();
                chk("width", width_meas, mon_r.w);
                chk("period", period_meas, mon_r.p);
                chk("pulse_num", pulse_num, mon_r.n);
                chk("busy_at_strobe", busy, !mon_r.fin);
                chk("done_at_strobe", done, mon_r.fin);
            end
        end
    end

    task automatic push(input int unsigned w, input int unsigned p, input int unsigned n, input bit fin);
        rec_t r;
        r.w = w; r.p = p; r.n = n; r.fin = fin;
        sb.push_back(r);
    endtask

    task automatic do_arm(input int pc, input int tmo);
        pulse_count = pc[15:0];
        timeout     = tmo;
        arm         = 1'b1;
        @(negedge clk);
        arm         = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        ttl_in = 1'b1;
        repeat (hi) @(negedge clk);
        ttl_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            n++;
            @(negedge clk);
        end
        idle_cyc = cyc;
        chk(tag, busy, 0);
    endtask

    initial begin
        int n;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mv", meas_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_to", timed_out, 0);
        chk("rst_num", pulse_num, 0);
        chk("rst_width", width_meas, 0);
        chk("rst_period", period_meas, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // pulse train with target count
        do_arm(3, 0);
        push(5, 0, 1, 0); push(5, 20, 2, 0); push(5, 20, 3, 1);
        repeat (3) pulse(5, 15);
        wait_idle("train_idle", 100);
        chk("train_done", done, 1);
        chk("train_to", timed_out, 0);
        chk("train_num", pulse_num, 3);

        // timeout with no input
        repeat (5) @(negedge clk);
        do_arm(0, 50);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_busy_cycles", n, 50);
        chk("tmo_done", done, 1);
        chk("tmo_to", timed_out, 1);
        chk("tmo_num", pulse_num, 0);

        // input already high at arm
        ttl_in = 1'b1;
        repeat (8) @(negedge clk);
        do_arm(1, 0);
        push(4, 0, 1, 1);
        repeat (10) @(negedge clk);
        ttl_in = 1'b0;
        repeat (5) @(negedge clk);
        pulse(4, 10);
        wait_idle("prehigh_idle", 100);
        chk("prehigh_num", pulse_num, 1);
        chk("prehigh_to", timed_out, 0);

        // saturation on the narrow instance
        pc8 = 16'd1; arm8 = 1'b1;
        @(negedge clk);
        arm8 = 1'b0;
        ttl8 = 1'b1;
        repeat (300) @(negedge clk);
        ttl8 = 1'b0;
        n = 0;
        while (!mv8 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("sat_strobe", mv8, 1);
        chk("sat_width", width8, 255);
        chk("sat_period", period8, 0);
        chk("sat_done", done8, 1);
        chk("sat_busy", busy8, 0);

        // free-running with timeout, arm while busy must be ignored
        repeat (5) @(negedge clk);
        do_arm(0, 100);
        push(3, 0, 1, 0); push(3, 10, 2, 0); push(3, 10, 3, 0); push(3, 10, 4, 0);
        fork
            repeat (4) pulse(3, 7);
            begin
                repeat (12) @(negedge clk);
                pulse_count = 16'd1;
                timeout     = 32'd5;
                arm         = 1'b1;
                @(negedge clk);
                arm         = 1'b0;
            end
        join
        wait_idle("free_idle", 300);
        chk("free_gap", idle_cyc - last_mv_cyc, 100);
        chk("free_to", timed_out, 1);
        chk("free_done", done, 1);
        chk("free_num", pulse_num, 4);

        // reset during a high phase
        repeat (5) @(negedge clk);
        do_arm(0, 0);
        push(5, 0, 1, 0);
        pulse(5, 5);
        ttl_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_state", dut.state_q, ST_IDLE);
        chk("mid_rst_num", pulse_num, 0);
        chk("mid_rst_width", width_meas, 0);
        chk("mid_rst_done", done, 0);
        ttl_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_mv", meas_valid, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_arm(2, 0);
        push(6, 0, 1, 0); push(6, 15, 2, 1);
        repeat (2) pulse(6, 9);
        wait_idle("post_rst_idle", 100);
        chk("post_rst_num", pulse_num, 2);

        // one-cycle high and low phases
        repeat (5) @(negedge clk);
        do_arm(3, 0);
        push(1, 0, 1, 0); push(1, 2, 2, 0); push(1, 2, 3, 1);
        repeat (3) pulse(1, 1);
        repeat (5) @(negedge clk);
        wait_idle("min_idle", 100);
        chk("min_num", pulse_num, 3);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
